// File: rtl/branch_target_buffer_if.sv
// Fetch/execute-side bus of the branch target buffer: lookup, prediction, update and flush.
// Optional statistics outputs exist only when BTB_STATS_EN is defined.
interface branch_target_buffer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              btb_lookup_valid;
    logic [ADDR_W-1:0] btb_lookup_pc;
    logic              btb_pred_valid;
    logic              btb_pred_hit;
    logic              btb_pred_taken;
    logic [ADDR_W-1:0] btb_pred_target;
    logic              btb_update_valid;
    logic [ADDR_W-1:0] btb_update_pc;
    logic              btb_update_taken;
    logic [ADDR_W-1:0] btb_update_target;
    logic              btb_flush;
`ifdef BTB_STATS_EN
    logic [15:0]       btb_stat_lookups;
    logic [15:0]       btb_stat_hits;
    logic [15:0]       btb_stat_mispredicts;

    modport master (
        output btb_lookup_valid, btb_lookup_pc,
        output btb_update_valid, btb_update_pc, btb_update_taken, btb_update_target,
        output btb_flush,
        input  btb_pred_valid, btb_pred_hit, btb_pred_taken, btb_pred_target,
        input  btb_stat_lookups, btb_stat_hits, btb_stat_mispredicts
    );

    modport slave (
        input  btb_lookup_valid, btb_lookup_pc,
        input  btb_update_valid, btb_update_pc, btb_update_taken, btb_update_target,
        input  btb_flush,
        output btb_pred_valid, btb_pred_hit, btb_pred_taken, btb_pred_target,
        output btb_stat_lookups, btb_stat_hits, btb_stat_mispredicts
    );
`else
    modport master (
        output btb_lookup_valid, btb_lookup_pc,
        output btb_update_valid, btb_update_pc, btb_update_taken, btb_update_target,
        output btb_flush,
        input  btb_pred_valid, btb_pred_hit, btb_pred_taken, btb_pred_target
    );

    modport slave (
        input  btb_lookup_valid, btb_lookup_pc,
        input  btb_update_valid, btb_update_pc, btb_update_taken, btb_update_target,
        input  btb_flush,
        output btb_pred_valid, btb_pred_hit, btb_pred_taken, btb_pred_target
    );
`endif
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with registered one-cycle lookup and saturating counters.
// Define BTB_STATS_EN to add saturating lookup/hit/mispredict statistics counters.
module branch_target_buffer #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CTR_W   = 2
) (
    input  logic                   btb_clk,
    input  logic                   btb_rst_n,
    branch_target_buffer_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));

    // Table storage kept in flops so reset and flush can touch every entry at once
    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];

    logic              pred_valid_q;
    logic              pred_hit_q;
    logic              pred_taken_q;
    logic [ADDR_W-1:0] pred_target_q;

    logic [IDX_W-1:0]  lk_idx_c;
    logic [TAG_W-1:0]  lk_tag_c;
    logic              lk_hit_c;
    logic [IDX_W-1:0]  up_idx_c;
    logic [TAG_W-1:0]  up_tag_c;
    logic              up_hit_c;
    logic [CTR_W-1:0]  ctr_next_c;
    logic              unused_pc_bits_c;

    assign lk_idx_c = bus.btb_lookup_pc[IDX_W+1:2];
    assign lk_tag_c = bus.btb_lookup_pc[ADDR_W-1:IDX_W+2];
    assign up_idx_c = bus.btb_update_pc[IDX_W+1:2];
    assign up_tag_c = bus.btb_update_pc[ADDR_W-1:IDX_W+2];

    assign lk_hit_c = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c);
    assign up_hit_c = valid_q[up_idx_c] && (tag_q[up_idx_c] == up_tag_c);

    // Instruction-alignment bits never participate in indexing or tagging
    assign unused_pc_bits_c = ^{bus.btb_lookup_pc[1:0], bus.btb_update_pc[1:0]};

    // Saturating counter step for the entry being updated
    always_comb begin
        ctr_next_c = ctr_q[up_idx_c];
        if (bus.btb_update_taken) begin
            if (ctr_q[up_idx_c] != CTR_MAX) begin
                ctr_next_c = ctr_q[up_idx_c] + CTR_W'(1);
            end
        end else begin
            if (ctr_q[up_idx_c] != '0) begin
                ctr_next_c = ctr_q[up_idx_c] - CTR_W'(1);
            end
        end
    end

    // Prediction register: reads the table before any same-edge update or flush lands
    always_ff @(posedge btb_clk or negedge btb_rst_n) begin
        if (!btb_rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q  <= bus.btb_lookup_valid;
            pred_hit_q    <= bus.btb_lookup_valid && lk_hit_c;
            pred_taken_q  <= bus.btb_lookup_valid && lk_hit_c && ctr_q[lk_idx_c][CTR_W-1];
            pred_target_q <= (bus.btb_lookup_valid && lk_hit_c) ? target_q[lk_idx_c] : '0;
        end
    end

    // Table write: flush has priority and drops a coincident update
    always_ff @(posedge btb_clk or negedge btb_rst_n) begin
        if (!btb_rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (bus.btb_flush) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (bus.btb_update_valid) begin
            if (up_hit_c) begin
                ctr_q[up_idx_c] <= ctr_next_c;
                if (bus.btb_update_taken) begin
                    target_q[up_idx_c] <= bus.btb_update_target;
                end
            end else if (bus.btb_update_taken) begin
                valid_q[up_idx_c]  <= 1'b1;
                tag_q[up_idx_c]    <= up_tag_c;
                target_q[up_idx_c] <= bus.btb_update_target;
                ctr_q[up_idx_c]    <= CTR_WT;
            end
        end
    end

    assign bus.btb_pred_valid  = pred_valid_q;
    assign bus.btb_pred_hit    = pred_hit_q;
    assign bus.btb_pred_taken  = pred_taken_q;
    assign bus.btb_pred_target = pred_target_q;

`ifdef BTB_STATS_EN
    logic [15:0] stat_lookups_q;
    logic [15:0] stat_hits_q;
    logic [15:0] stat_mispredicts_q;
    logic        up_pred_taken_c;
    logic        mispredict_c;

    assign up_pred_taken_c = up_hit_c && ctr_q[up_idx_c][CTR_W-1];
    assign mispredict_c    = (up_pred_taken_c != bus.btb_update_taken) ||
                             (up_hit_c && bus.btb_update_taken &&
                              (target_q[up_idx_c] != bus.btb_update_target));

    // Statistics survive flush; a dropped (flushed) update is not scored
    always_ff @(posedge btb_clk or negedge btb_rst_n) begin
        if (!btb_rst_n) begin
            stat_lookups_q     <= '0;
            stat_hits_q        <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (bus.btb_lookup_valid && (stat_lookups_q != 16'hFFFF)) begin
                stat_lookups_q <= stat_lookups_q + 16'd1;
            end
            if (bus.btb_lookup_valid && lk_hit_c && (stat_hits_q != 16'hFFFF)) begin
                stat_hits_q <= stat_hits_q + 16'd1;
            end
            if (bus.btb_update_valid && !bus.btb_flush && mispredict_c &&
                (stat_mispredicts_q != 16'hFFFF)) begin
                stat_mispredicts_q <= stat_mispredicts_q + 16'd1;
            end
        end
    end

    assign bus.btb_stat_lookups     = stat_lookups_q;
    assign bus.btb_stat_hits        = stat_hits_q;
    assign bus.btb_stat_mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES=16, ADDR_W=32, CTR_W=2).
module tb_branch_target_buffer;
    localparam int unsigned ADDR_W = 32;

    typedef logic [ADDR_W+2:0] obs_t;  // {pred_valid, pred_hit, pred_taken, pred_target}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    obs_t obs;
    obs_t exp;

    always #5 clk = ~clk;

    branch_target_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    branch_target_buffer #(.ENTRIES(16), .ADDR_W(ADDR_W), .CTR_W(2)) dut (
        .btb_clk   (clk),
        .btb_rst_n (rst_n),
        .bus       (bus)
    );

    function automatic obs_t pred_now();
        return {bus.btb_pred_valid, bus.btb_pred_hit, bus.btb_pred_taken, bus.btb_pred_target};
    endfunction

    function automatic obs_t mk(input logic v, input logic h, input logic t, input logic [ADDR_W-1:0] tgt);
        return {v, h, t, tgt};
    endfunction

    task automatic idle_inputs();
        bus.btb_lookup_valid  = 1'b0;
        bus.btb_lookup_pc     = '0;
        bus.btb_update_valid  = 1'b0;
        bus.btb_update_pc     = '0;
        bus.btb_update_taken  = 1'b0;
        bus.btb_update_target = '0;
        bus.btb_flush         = 1'b0;
    endtask

    task automatic lookup(input logic [ADDR_W-1:0] pc, output obs_t o);
        @(negedge clk);
        bus.btb_lookup_valid = 1'b1;
        bus.btb_lookup_pc    = pc;
        @(negedge clk);
        bus.btb_lookup_valid = 1'b0;
        o = pred_now();
    endtask

    task automatic update(input logic [ADDR_W-1:0] pc, input logic taken, input logic [ADDR_W-1:0] tgt);
        @(negedge clk);
        bus.btb_update_valid  = 1'b1;
        bus.btb_update_pc     = pc;
        bus.btb_update_taken  = taken;
        bus.btb_update_target = tgt;
        @(negedge clk);
        bus.btb_update_valid  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #3;
        obs = pred_now(); exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_outputs got %h exp %h", obs, exp); end
`ifdef BTB_STATS_EN
        checks++;
        if ({bus.btb_stat_lookups, bus.btb_stat_hits, bus.btb_stat_mispredicts} !== 48'h0) begin
            errors++; $display("FAIL reset_stats got %h exp 0",
                               {bus.btb_stat_lookups, bus.btb_stat_hits, bus.btb_stat_mispredicts});
        end
`endif
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        obs = pred_now(); exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL idle_after_reset got %h exp %h", obs, exp); end
    endtask

    task automatic test_miss();
        lookup(32'h100, obs); exp = mk(1'b1, 1'b0, 1'b0, 32'h0); checks++;
        if (obs !== exp) begin errors++; $display("FAIL cold_miss got %h exp %h", obs, exp); end
        @(negedge clk);
        obs = pred_now(); exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL no_lookup_zero got %h exp %h", obs, exp); end
    endtask

    task automatic test_allocate();
        update(32'h100, 1'b1, 32'h200);
        lookup(32'h100, obs); exp = mk(1'b1, 1'b1, 1'b1, 32'h200); checks++;
        if (obs !== exp) begin errors++; $display("FAIL allocate_hit got %h exp %h", obs, exp); end
    endtask

    task automatic test_counter_walk();
        logic              tk  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [ADDR_W-1:0] tg  [8] = '{32'h200, 32'h200, 32'hDEAD0, 32'hDEAD0,
                                       32'hDEAD0, 32'hDEAD0, 32'h208, 32'h208};
        logic              ept [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [ADDR_W-1:0] etg [8] = '{32'h200, 32'h200, 32'h200, 32'h200,
                                       32'h200, 32'h200, 32'h208, 32'h208};
        for (int i = 0; i < 8; i++) begin
            update(32'h100, tk[i], tg[i]);
            lookup(32'h100, obs); exp = mk(1'b1, 1'b1, ept[i], etg[i]); checks++;
            if (obs !== exp) begin errors++; $display("FAIL counter_walk_%0d got %h exp %h", i, obs, exp); end
        end
    endtask

    task automatic test_alias();
        update(32'h140, 1'b0, 32'h999);
        lookup(32'h100, obs); exp = mk(1'b1, 1'b1, 1'b1, 32'h208); checks++;
        if (obs !== exp) begin errors++; $display("FAIL miss_not_taken_no_change got %h exp %h", obs, exp); end
        update(32'h140, 1'b1, 32'h300);
        lookup(32'h100, obs); exp = mk(1'b1, 1'b0, 1'b0, 32'h0); checks++;
        if (obs !== exp) begin errors++; $display("FAIL alias_evicted got %h exp %h", obs, exp); end
        lookup(32'h140, obs); exp = mk(1'b1, 1'b1, 1'b1, 32'h300); checks++;
        if (obs !== exp) begin errors++; $display("FAIL alias_new_hit got %h exp %h", obs, exp); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        bus.btb_lookup_valid  = 1'b1; bus.btb_lookup_pc = 32'h180;
        bus.btb_update_valid  = 1'b1; bus.btb_update_pc = 32'h180;
        bus.btb_update_taken  = 1'b1; bus.btb_update_target = 32'h400;
        @(negedge clk);
        bus.btb_lookup_valid = 1'b0; bus.btb_update_valid = 1'b0;
        obs = pred_now(); exp = mk(1'b1, 1'b0, 1'b0, 32'h0); checks++;
        if (obs !== exp) begin errors++; $display("FAIL read_before_write got %h exp %h", obs, exp); end
        lookup(32'h180, obs); exp = mk(1'b1, 1'b1, 1'b1, 32'h400); checks++;
        if (obs !== exp) begin errors++; $display("FAIL write_visible_next got %h exp %h", obs, exp); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.btb_flush         = 1'b1;
        bus.btb_lookup_valid  = 1'b1; bus.btb_lookup_pc = 32'h180;
        bus.btb_update_valid  = 1'b1; bus.btb_update_pc = 32'h1C0;
        bus.btb_update_taken  = 1'b1; bus.btb_update_target = 32'h500;
        @(negedge clk);
        idle_inputs();
        obs = pred_now(); exp = mk(1'b1, 1'b1, 1'b1, 32'h400); checks++;
        if (obs !== exp) begin errors++; $display("FAIL flush_cycle_preflush got %h exp %h", obs, exp); end
        lookup(32'h1C0, obs); exp = mk(1'b1, 1'b0, 1'b0, 32'h0); checks++;
        if (obs !== exp) begin errors++; $display("FAIL flush_drops_update got %h exp %h", obs, exp); end
        lookup(32'h180, obs); exp = mk(1'b1, 1'b0, 1'b0, 32'h0); checks++;
        if (obs !== exp) begin errors++; $display("FAIL flush_invalidates got %h exp %h", obs, exp); end
    endtask

    task automatic test_async_reset();
        update(32'h100, 1'b1, 32'h200);
        @(negedge clk);
        bus.btb_lookup_valid = 1'b1; bus.btb_lookup_pc = 32'h100;
        @(posedge clk); #1;
        obs = pred_now(); exp = mk(1'b1, 1'b1, 1'b1, 32'h200); checks++;
        if (obs !== exp) begin errors++; $display("FAIL pre_reset_hit got %h exp %h", obs, exp); end
        #1 rst_n = 1'b0;
        #1;
        obs = pred_now(); exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL async_reset_clear got %h exp %h", obs, exp); end
`ifdef BTB_STATS_EN
        checks++;
        if ({bus.btb_stat_lookups, bus.btb_stat_hits, bus.btb_stat_mispredicts} !== 48'h0) begin
            errors++; $display("FAIL async_reset_stats got %h exp 0",
                               {bus.btb_stat_lookups, bus.btb_stat_hits, bus.btb_stat_mispredicts});
        end
`endif
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        lookup(32'h100, obs); exp = mk(1'b1, 1'b0, 1'b0, 32'h0); checks++;
        if (obs !== exp) begin errors++; $display("FAIL post_reset_miss got %h exp %h", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_allocate();
        test_counter_walk();
        test_alias();
        test_same_cycle();
        test_flush();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Parametrised, direct-mapped branch target buffer for the fetch stage. It generalises the single 2-bit prediction FSM into an indexed table. Each entry holds a valid bit, tag, target address and CTR_W-bit saturating counter. Fetch performs a lookup with a registered, one-cycle-latency prediction; execute writes back resolved branch outcomes through a separate update port.

Parameters:
ENTRIES, 16, number of table entries; power of two, min 2
ADDR_W, 32, PC/target width in bits
CTR_W, 2, saturating counter width; min 1
(derived) IDX_W = log2(ENTRIES); TAG_W = ADDR_W - IDX_W - 2

Ports:
btb_clk  in  1  clock, rising edge
btb_rst_n  in  1  asynchronous active-low reset
btb_lookup_valid  in  1  lookup request this cycle
btb_lookup_pc  in  ADDR_W  fetch PC to look up
btb_pred_valid  out  1  prediction valid (registered)
btb_pred_hit  out  1  valid entry with matching tag
btb_pred_taken  out  1  predicted taken (hit and counter MSB = 1)
btb_pred_target  out  ADDR_W  stored target; 0 on miss
btb_update_valid  in  1  resolved branch write-back
btb_update_pc  in  ADDR_W  PC of the resolved branch
btb_update_taken  in  1  actual outcome
btb_update_target  in  ADDR_W  actual target when taken
btb_flush  in  1  synchronous invalidate of all entries

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. PC bits [1:0] are ignored.
- Reset (async, btb_rst_n=0):
  - All valid bits = 0; all counters = weakly not-taken (2^(CTR_W-1) - 1).
  - btb_pred_valid, btb_pred_hit, btb_pred_taken = 0; btb_pred_target = 0.
  - Outputs clear immediately on assertion, not at the next edge. Reset mid-operation discards any in-flight prediction.
- Lookup latency is 1 cycle. A lookup at edge N produces outputs valid for the cycle after N.
  - btb_pred_valid mirrors the previous cycle's btb_lookup_valid.
  - With no lookup, btb_pred_valid = 0 and the other pred outputs = 0.
- Miss (invalid entry or tag mismatch): hit=0, taken=0, target=0.
- Counter rules: taken increments, saturating at 2^CTR_W - 1; not-taken decrements, saturating at 0. Predict taken when MSB = 1.
- Update hit: apply the counter rule. If taken, overwrite the target with btb_update_target.
- Update miss, taken: allocate (replace) the entry. Set valid=1, write tag and target, counter = weakly taken (2^(CTR_W-1)).
- Update miss, not-taken: no change to the table.
- Lookup and update in the same cycle, same index: the lookup returns pre-update contents (read-before-write). The update is visible from the next lookup onward.
- Flush: all valid bits cleared at the edge; counters untouched. Flush and update in the same cycle: flush wins and the update is dropped. A lookup in a flush cycle returns the pre-flush state.
- Table registers are reset-clearable; no memory macro is inferred.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined: adds three 16-bit outputs, btb_stat_lookups, btb_stat_hits and btb_stat_mispredicts. Each saturates at 0xFFFF and is cleared by reset only, not by flush.
  - btb_stat_lookups counts lookup requests; btb_stat_hits counts lookups that hit.
  - A mispredict is an update whose pre-update prediction (taken = hit and MSB = 1) differs from btb_update_taken. A taken hit whose stored target differs from btb_update_target also counts.
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Test Plan:
1. Reset, then lookup 0x100 -> next cycle pred_valid=1, hit=0, taken=0, target=0x0.
2. Update 0x100 taken, target 0x200; then lookup 0x100 -> hit=1, taken=1 (ctr=2'b10), target=0x200.
3. Counter walk at 0x100: one more taken -> ctr 11; not-taken -> 10 (taken=1); not-taken -> 01 (taken=0); two more not-taken -> 00, stays 00, hit=1.
4. Alias (ENTRIES=16): update 0x140 taken, target 0x300 (same index 0) -> lookup 0x100 hit=0; lookup 0x140 hit=1, target=0x300.
5. Same cycle: lookup 0x180 with update 0x180 taken, target 0x400 -> that lookup misses; next lookup 0x180 hit=1, target=0x400. Flush plus update 0x1C0 in the same cycle -> lookup 0x1C0 hit=0.
6. Drop btb_rst_n mid-stream while pred_valid=1 -> pred outputs go to 0 without waiting for a clock edge; after release, lookup of 0x200-target entry misses. With BTB_STATS_EN: counters read 0.
